timer_dev: RTL and testbench

- Memory-mapped 32-bit down-counting timer; the responder that sits behind the system bridge's device-side write enable, address and write-data bus.
- Two instances are used: Timer0 at 0x7F00–0x7F0B and Timer1 at 0x7F10–0x7F1B.
- The bridge decodes the base address; this block decodes only word offset addr[3:2].
- Raises a level interrupt request to the CPU's external-interrupt input.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_dev_if.sv | 13 +
 rtl/timer_dev.sv | 127 ++++++++++++
 tb/tb_timer_dev.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: register offsets,
// CTRL bit positions, MODE encodings and FSM state encoding.
`timescale 1ns/1ps
package timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_dev_if.sv
// Device-side bridge bus for the timer: write enable, address, write data,
// combinational read data and the level interrupt request.
`timescale 1ns/1ps
interface timer_dev_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    modport master (output addr, we, wd, input rd, irq);
    modport slave  (input addr, we, wd, output rd, irq);
endinterface

// File: rtl/timer_dev.sv
// 32-bit down-counting timer with CTRL/PRESET/COUNT registers and a level irq.
// Optional TIMER_STATUS_EN macro turns offset 3 into a STATUS register.
`timescale 1ns/1ps
module timer_dev
    import timer_pkg::*;
#(
    parameter logic [31:0] PRESET_RESET = 32'h0000_0000,
    parameter logic [3:0]  CTRL_RESET   = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus
);

    state_t      state_reg, state_next;
    logic [3:0]  ctrl_reg, ctrl_next;
    logic [31:0] preset_reg, preset_next;
    logic [31:0] count_reg, count_next;
    logic        irq_pending_reg, irq_pending_next;

    logic [1:0]  offset;
    logic        wr_ctrl, wr_preset, wr_status;
    logic        set_pending, hw_clear_pending;
    logic [1:0]  mode;
    logic [31:0] status_word;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign offset    = bus.addr[3:2];
    assign wr_ctrl   = bus.we && (offset == OFF_CTRL);
    assign wr_preset = bus.we && (offset == OFF_PRESET);
    assign mode      = ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

`ifdef TIMER_STATUS_EN
    assign wr_status   = bus.we && (offset == OFF_STATUS) && bus.wd[0];
    assign status_word = {29'b0, state_reg, irq_pending_reg};
`else
    assign wr_status   = 1'b0;
    assign status_word = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            ctrl_reg        <= CTRL_RESET;
            preset_reg      <= PRESET_RESET;
            count_reg       <= 32'h0;
            irq_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ctrl_reg        <= ctrl_next;
            preset_reg      <= preset_next;
            count_reg       <= count_next;
            irq_pending_reg <= irq_pending_next;
        end
    end

    // Transitions look only at the registered CTRL, so a CPU write acts one edge later.
    always_comb begin
        state_next       = state_reg;
        ctrl_next        = ctrl_reg;
        preset_next      = preset_reg;
        count_next       = count_reg;
        irq_pending_next = irq_pending_reg;
        set_pending      = 1'b0;
        hw_clear_pending = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ctrl_reg[CTRL_EN]) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (ctrl_reg[CTRL_EN]) begin
                    count_next = preset_reg;
                    state_next = ST_CNT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!ctrl_reg[CTRL_EN]) begin
                    state_next = ST_IDLE;
                end else if (count_reg > 32'd1) begin
                    count_next = count_reg - 32'd1;
                end else begin
                    count_next  = 32'h0;
                    set_pending = 1'b1;
                    state_next  = ST_INT;
                end
            end
            ST_INT: begin
                if (mode == MODE_RELOAD) begin
                    hw_clear_pending = 1'b1;
                    state_next       = ST_LOAD;
                end else begin
                    ctrl_next[CTRL_EN] = 1'b0;
                    state_next         = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // CPU write overrides the hardware EN clear.
        if (wr_ctrl)   ctrl_next   = bus.wd[3:0];
        if (wr_preset) preset_next = bus.wd;

        // A same-cycle set of the pending flag wins over every clear source.
        if (wr_ctrl || wr_status || hw_clear_pending) irq_pending_next = 1'b0;
        if (set_pending)                              irq_pending_next = 1'b1;
    end

    always_comb begin
        rd_word = 32'h0;
        case (offset)
            OFF_CTRL:   rd_word = {28'b0, ctrl_reg};
            OFF_PRESET: rd_word = preset_reg;
            OFF_COUNT:  rd_word = count_reg;
            OFF_STATUS: rd_word = status_word;
            default:    rd_word = 32'h0;
        endcase
    end

    assign bus.rd  = rd_word;
    assign bus.irq = irq_pending_reg & ctrl_reg[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios with fixed expectations
// plus randomized bus traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_timer_dev;
    import timer_pkg::*;

    localparam logic [31:0] PRESET_RESET = 32'h0000_0000;
    localparam logic [3:0]  CTRL_RESET   = 4'h0;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_dev_if bus ();

    timer_dev #(
        .PRESET_RESET (PRESET_RESET),
        .CTRL_RESET   (CTRL_RESET)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_phase;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            OFF_CTRL:   return {28'b0, m_ctrl};
            OFF_PRESET: return m_preset;
            OFF_COUNT:  return m_count;
            default: begin
`ifdef TIMER_STATUS_EN
                return {29'b0, 2'(m_phase), m_pend};
`else
                return 32'h0;
`endif
            end
        endcase
    endfunction

    // Advance the model by one rising edge given the bus inputs seen at that edge.
    function automatic void m_step(input bit rst, input bit wr, input logic [1:0] off,
                                   input logic [31:0] data);
        bit en, reload, set_p, clr_p;
        if (rst) begin
            m_phase  = PH_IDLE;
            m_ctrl   = CTRL_RESET;
            m_preset = PRESET_RESET;
            m_count  = 32'h0;
            m_pend   = 1'b0;
            return;
        end
        en     = m_ctrl[0];
        reload = (m_ctrl[2:1] == MODE_RELOAD);
        set_p  = 1'b0;
        clr_p  = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (en) m_phase = PH_LOAD;
        end else if (m_phase == PH_LOAD) begin
            if (en) begin
                m_count = m_preset;
                m_phase = PH_CNT;
            end else begin
                m_phase = PH_IDLE;
            end
        end else if (m_phase == PH_CNT) begin
            if (!en) m_phase = PH_IDLE;
            else if (m_count <= 32'd1) begin
                m_count = 32'h0;
                set_p   = 1'b1;
                m_phase = PH_INT;
            end else begin
                m_count = m_count - 32'd1;
            end
        end else begin
            if (reload) begin
                clr_p   = 1'b1;
                m_phase = PH_LOAD;
            end else begin
                m_ctrl[0] = 1'b0;
                m_phase   = PH_IDLE;
            end
        end
        if (wr && off == OFF_CTRL) begin
            m_ctrl = data[3:0];
            clr_p  = 1'b1;
        end
        if (wr && off == OFF_PRESET) m_preset = data;
`ifdef TIMER_STATUS_EN
        if (wr && off == OFF_STATUS && data[0]) clr_p = 1'b1;
`endif
        if (clr_p) m_pend = 1'b0;
        if (set_p) m_pend = 1'b1;
    endfunction

    // One clock cycle: drive inputs, take the edge, update model, compare outputs.
    task automatic tick(input bit rst, input bit wr, input logic [1:0] off, input logic [31:0] data);
        reset    = rst;
        bus.we   = wr;
        bus.addr = ($urandom() & 32'hFFFF_FFF3) | {28'b0, off, 2'b00};
        bus.wd   = data;
        @(posedge clk);
        m_step(rst, wr, off, data);
        #1;
        check("irq", {31'b0, bus.irq}, {31'b0, m_pend & m_ctrl[3]});
        check("rd", bus.rd, m_read(off));
        if (wr || rst)
            $display("txn t=%0t rst=%0b we=%0b off=%0d wd=%h rd=%h irq=%0b",
                     $time, rst, wr, off, data, bus.rd, bus.irq);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        tick(1'b0, 1'b1, off, data);
    endtask

    task automatic idle(input logic [1:0] off);
        tick(1'b0, 1'b0, off, 32'h0);
    endtask

    task automatic rdchk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        bus.we   = 1'b0;
        bus.addr = 32'h0000_7F10 | {28'b0, off, 2'b00};
        #1;
        check(tag, bus.rd, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [1:0] roff;
        logic [31:0] rdata;

        reset    = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h0;
        bus.wd   = 32'h0;

        // Reset, including a write that reset must override
        tick(1'b1, 1'b0, OFF_CTRL, 32'h0);
        tick(1'b1, 1'b1, OFF_PRESET, 32'hDEAD_BEEF);
        rdchk("rst_ctrl", OFF_CTRL, 32'h0);
        rdchk("rst_preset", OFF_PRESET, PRESET_RESET);
        rdchk("rst_count", OFF_COUNT, 32'h0);
        rdchk("rst_off3", OFF_STATUS, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);

        // One-shot, PRESET=5: irq exactly 7 edges after the CTRL write
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            idle(OFF_COUNT);
            check("os_count", bus.rd, (k == 1) ? 32'd0 : 32'(7 - k));
            check("os_irq", {31'b0, bus.irq}, 32'(k == 7));
        end
        idle(OFF_CTRL);
        check("os_ctrl_en_clr", bus.rd, 32'h8);
        idle(OFF_COUNT);
        idle(OFF_COUNT);
        check("os_irq_hold", {31'b0, bus.irq}, 32'h1);
        wr(OFF_CTRL, 32'h8);
        check("os_irq_ack", {31'b0, bus.irq}, 32'h0);

        // Auto-reload, PRESET=3: 1-cycle pulses every 5 cycles
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            idle(OFF_CTRL);
            check("rl_irq", {31'b0, bus.irq}, 32'(k >= 5 && (k - 5) % 5 == 0));
            check("rl_ctrl", bus.rd, 32'hB);
        end
        wr(OFF_CTRL, 32'h0);
        repeat (3) idle(OFF_COUNT);

        // Disable mid-count freezes COUNT; re-enable reloads from PRESET
        wr(OFF_PRESET, 32'd6);
        wr(OFF_CTRL, 32'h9);
        repeat (3) idle(OFF_COUNT);
        idle(OFF_COUNT);
        check("frz_pre", bus.rd, 32'd4);
        wr(OFF_CTRL, 32'h0);
        for (int k = 0; k < 4; k++) begin
            idle(OFF_COUNT);
            check("frz_count", bus.rd, 32'd3);
            check("frz_irq", {31'b0, bus.irq}, 32'h0);
        end
        wr(OFF_CTRL, 32'h9);
        idle(OFF_COUNT);
        idle(OFF_COUNT);
        check("restart_load", bus.rd, 32'd6);
        idle(OFF_COUNT);
        check("restart_dec", bus.rd, 32'd5);
        wr(OFF_CTRL, 32'h0);
        repeat (3) idle(OFF_COUNT);

        // PRESET=0 behaves as 1; COUNT writes ignored; IM=0 masks irq
        wr(OFF_PRESET, 32'd0);
        wr(OFF_CTRL, 32'h9);
        wr(OFF_COUNT, 32'h55);
        idle(OFF_COUNT);
        check("p0_count", bus.rd, 32'd0);
        check("p0_irq_early", {31'b0, bus.irq}, 32'h0);
        idle(OFF_COUNT);
        check("p0_irq", {31'b0, bus.irq}, 32'h1);
        wr(OFF_CTRL, 32'h1);
        for (int k = 0; k < 4; k++) begin
            idle(OFF_CTRL);
            check("im0_irq", {31'b0, bus.irq}, 32'h0);
        end
        rdchk("im0_ctrl", OFF_CTRL, 32'h0);
`ifdef TIMER_STATUS_EN
        rdchk("status_pend", OFF_STATUS, 32'h1);
        wr(OFF_STATUS, 32'h1);
        check("status_clr", bus.rd, 32'h0);
        rdchk("status_ctrl_kept", OFF_CTRL, 32'h0);
`else
        wr(OFF_STATUS, 32'hFFFF_FFFF);
        check("off3_zero", bus.rd, 32'h0);
`endif

        // Reset during CNT with COUNT=2
        wr(OFF_PRESET, 32'd4);
        wr(OFF_CTRL, 32'h9);
        repeat (4) idle(OFF_COUNT);
        check("pre_rst_count", bus.rd, 32'd2);
        tick(1'b1, 1'b0, OFF_COUNT, 32'h0);
        rdchk("mid_rst_ctrl", OFF_CTRL, 32'h0);
        rdchk("mid_rst_preset", OFF_PRESET, PRESET_RESET);
        rdchk("mid_rst_count", OFF_COUNT, 32'h0);
        check("mid_rst_irq", {31'b0, bus.irq}, 32'h0);
        idle(OFF_COUNT);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r    = int'($urandom_range(0, 99));
            roff = 2'($urandom_range(0, 3));
            if (r < 2) begin
                tick(1'b1, 1'b0, roff, 32'h0);
            end else if (r < 35) begin
                if (roff == OFF_CTRL)        rdata = 32'($urandom_range(0, 15));
                else if (roff == OFF_PRESET) rdata = 32'($urandom_range(0, 6));
                else                         rdata = $urandom();
                wr(roff, rdata);
            end else begin
                idle(roff);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
